// File: rtl/serdes_pkg.sv
// Shared types and constants for the framed serial link.
package serdes_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serdes_framed_core_if.sv
// Parallel-side handshake bundle of the framed serial link.
interface serdes_framed_core_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_err
  );

endinterface

// File: rtl/serdes_rx_sampler.sv
// RX path: 2-flop synchroniser, mid-bit sampling FSM and shift register.
module serdes_rx_sampler
  import serdes_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DIV       = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_err_q, rx_err_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              s;

  assign s = sync2_q;

  // State register, synchroniser and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      sync1_q    <= LINE_IDLE;
      sync2_q    <= LINE_IDLE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
    end
  end

  // Next state: start detect, false-start reject, mid-bit data capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    sync1_d = line_in;
    sync2_d = sync1_q;
    case (state_q)
      RX_IDLE: begin
        if (!s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          sh_d  = MSB_FIRST ? ((sh_q << 1) | DATA_W'(s))
                            : ((sh_q >> 1) | (DATA_W'(s) << (DATA_W - 1)));
          if (bit_q == BIT_LAST) state_d = RX_STOP;
          else                   bit_d   = bit_q + BIT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Outputs: stop-bit verdict becomes a valid or error pulse next cycle
  always_comb begin
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    rx_data_d  = rx_data_q;
    if (state_q == RX_STOP && cnt_q == CNT_LAST) begin
      rx_valid_d = s;
      rx_err_d   = !s;
      if (s) rx_data_d = sh_q;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;

endmodule

// File: rtl/serdes_framed_core.sv
// Framed full-duplex serial link: TX serialiser, loopback mux, RX sampler.
module serdes_framed_core
  import serdes_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DIV       = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serdes_framed_core_if.slave  bus,
  output logic                 ser_out,
  input  logic                 ser_in,
  input  logic                 loopback
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  tx_state_t         tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_word_q, tx_word_d;
  logic              ser_out_q, ser_out_d;
  logic              tx_ready_q, tx_ready_d;
  logic              rx_line;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_err;

  // TX state register and registered line/ready outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_word_q  <= '0;
      ser_out_q  <= LINE_IDLE;
      tx_ready_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_word_q  <= tx_word_d;
      ser_out_q  <= ser_out_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  // TX next state: accept in IDLE or last STOP cycle, then time each bit slot
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_word_d  = tx_word_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.tx_valid) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_word_d  = bus.tx_data;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BIT_LAST) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d  = tx_bit_q + BIT_W'(1);
            tx_word_d = MSB_FIRST ? (tx_word_q << 1) : (tx_word_q >> 1);
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (bus.tx_valid) begin
            tx_state_d = TX_START;
            tx_word_d  = bus.tx_data;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX outputs derived from the upcoming state so they register in step
  always_comb begin
    ser_out_d  = LINE_IDLE;
    tx_ready_d = 1'b0;
    case (tx_state_d)
      TX_START: ser_out_d = 1'b0;
      TX_DATA:  ser_out_d = MSB_FIRST ? tx_word_d[DATA_W-1] : tx_word_d[0];
      default:  ser_out_d = LINE_IDLE;
    endcase
    if (tx_state_d == TX_IDLE || (tx_state_d == TX_STOP && tx_cnt_d == CNT_LAST))
      tx_ready_d = 1'b1;
  end

  assign ser_out      = ser_out_q;
  assign bus.tx_ready = tx_ready_q;
  assign rx_line      = loopback ? ser_out_q : ser_in;

  serdes_rx_sampler #(
    .DATA_W    (DATA_W),
    .DIV       (DIV),
    .MSB_FIRST (MSB_FIRST)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_in  (rx_line),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;
  assign bus.rx_err   = rx_err;

endmodule

// File: tb/tb_serdes_framed_core.sv
// Scoreboard bench: LSB-first DUT (loopback and external line) plus MSB-first DUT in loopback.
module tb_serdes_framed_core;

  localparam int DW    = 8;
  localparam int DV    = 4;
  localparam int FRAME = DV * (DW + 2);

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ser_out_l, ser_out_m;
  logic ser_in_l;
  logic lb_l;
  wire  ser_in_m = 1'b1;
  wire  lb_m     = 1'b1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  exp_t    exp_l[$];
  exp_t    exp_m[$];
  exp_t    e_l, e_m;
  logic [DW-1:0] last_l = '0;
  logic [DW-1:0] last_m = '0;

  serdes_framed_core_if #(.DATA_W(DW)) bus_l ();
  serdes_framed_core_if #(.DATA_W(DW)) bus_m ();

  serdes_framed_core #(.DATA_W(DW), .DIV(DV), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .bus(bus_l),
    .ser_out(ser_out_l), .ser_in(ser_in_l), .loopback(lb_l)
  );

  serdes_framed_core #(.DATA_W(DW), .DIV(DV), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .bus(bus_m),
    .ser_out(ser_out_m), .ser_in(ser_in_m), .loopback(lb_m)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: LSB-first DUT
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (bus_l.rx_valid || bus_l.rx_err)) begin
      chk("rx_excl_l", 32'(bus_l.rx_valid & bus_l.rx_err), 0);
      if (exp_l.size() == 0) begin
        tests++; fails++;
        $display("FAIL rx_unexpected_l: got valid=%0b err=%0b data=0x%0h expected no pulse",
                 bus_l.rx_valid, bus_l.rx_err, bus_l.rx_data);
      end else begin
        e_l = exp_l.pop_front();
        chk("rx_kind_l", 32'(bus_l.rx_err), 32'(e_l.err));
        chk("rx_data_l", 32'(bus_l.rx_data), 32'(e_l.data));
      end
    end
  end

  // Monitor: MSB-first DUT
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (bus_m.rx_valid || bus_m.rx_err)) begin
      chk("rx_excl_m", 32'(bus_m.rx_valid & bus_m.rx_err), 0);
      if (exp_m.size() == 0) begin
        tests++; fails++;
        $display("FAIL rx_unexpected_m: got valid=%0b err=%0b data=0x%0h expected no pulse",
                 bus_m.rx_valid, bus_m.rx_err, bus_m.rx_data);
      end else begin
        e_m = exp_m.pop_front();
        chk("rx_kind_m", 32'(bus_m.rx_err), 32'(e_m.err));
        chk("rx_data_m", 32'(bus_m.rx_data), 32'(e_m.data));
      end
    end
  end

  // Offer a word and wait for the handshake; valid is left high afterwards
  task automatic send(input bit m, input logic [DW-1:0] w, output int acc);
    int n = 0;
    @(negedge clk);
    if (m) begin bus_m.tx_data = w; bus_m.tx_valid = 1'b1; end
    else   begin bus_l.tx_data = w; bus_l.tx_valid = 1'b1; end
    while (!(m ? bus_m.tx_ready : bus_l.tx_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tx_accept_timeout", 32'(n < 200), 1);
    acc = cyc;
    if (m) begin
      exp_m.push_back('{err: 1'b0, data: w}); last_m = w;
    end else if (lb_l) begin
      exp_l.push_back('{err: 1'b0, data: w}); last_l = w;
    end
    @(posedge clk);
  endtask

  task automatic drop(input bit m);
    if (m) bus_m.tx_valid = 1'b0;
    else   bus_l.tx_valid = 1'b0;
  endtask

  // Check each serial slot at its second cycle, starting right after an accept
  task automatic check_wave(input bit m, input logic [DW-1:0] w);
    logic [DW+1:0] bits;
    bits[0]    = 1'b0;
    bits[DW+1] = 1'b1;
    for (int i = 0; i < DW; i++) bits[i+1] = m ? w[DW-1-i] : w[i];
    @(negedge clk);
    drop(m);
    @(negedge clk);
    for (int i = 0; i < DW + 2; i++) begin
      chk($sformatf("ser_out_slot%0d", i), 32'(m ? ser_out_m : ser_out_l), 32'(bits[i]));
      chk("tx_ready_busy", 32'(m ? bus_m.tx_ready : bus_l.tx_ready), 0);
      repeat (DV) @(negedge clk);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    ser_in_l = b;
    repeat (DV - 1) @(negedge clk);
  endtask

  // External LSB-first frame on ser_in with a chosen stop bit
  task automatic ext_frame(input logic [DW-1:0] w, input logic stop);
    if (stop) begin
      exp_l.push_back('{err: 1'b0, data: w}); last_l = w;
    end else begin
      exp_l.push_back('{err: 1'b1, data: last_l});
    end
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(w[i]);
    drive_bit(stop);
    drive_bit(1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_l.size() != 0 || exp_m.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 2000), 1);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, gap;
    logic [DW-1:0] w;
    rst_n          = 1'b0;
    lb_l           = 1'b1;
    ser_in_l       = 1'b1;
    bus_l.tx_valid = 1'b0; bus_l.tx_data = '0;
    bus_m.tx_valid = 1'b0; bus_m.tx_data = '0;

    repeat (3) @(negedge clk);
    chk("rst_ser_out", 32'(ser_out_l), 1);
    chk("rst_tx_ready", 32'(bus_l.tx_ready), 1);
    chk("rst_rx_valid", 32'(bus_l.rx_valid), 0);
    chk("rst_rx_err", 32'(bus_l.rx_err), 0);
    chk("rst_rx_data", 32'(bus_l.rx_data), 0);
    chk("rst_ser_out_m", 32'(ser_out_m), 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Loopback waveform, LSB first
    send(1'b0, 8'hA5, a1);
    check_wave(1'b0, 8'hA5);
    drain();

    // Loopback waveform, MSB first
    send(1'b1, 8'h81, a1);
    check_wave(1'b1, 8'h81);
    drain();

    // Back-to-back frames with valid held
    send(1'b0, 8'h00, a1);
    send(1'b0, 8'hFF, a2);
    chk("b2b_frame_len", 32'(a2 - a1), FRAME);
    @(negedge clk);
    chk("b2b_start_now", 32'(ser_out_l), 0);
    drop(1'b0);
    drain();

    // Framing error on the external line
    lb_l = 1'b0;
    ext_frame(8'h3C, 1'b0);
    drain();
    chk("err_rx_data_held", 32'(bus_l.rx_data), 32'h0FF);

    // One-cycle glitch in idle, then a good frame
    @(negedge clk); ser_in_l = 1'b0;
    @(negedge clk); ser_in_l = 1'b1;
    repeat (20) @(negedge clk);
    ext_frame(8'h5A, 1'b1);
    drain();

    // Random external frames with random stop bits
    for (int i = 0; i < 8; i++) begin
      w = DW'($urandom);
      ext_frame(w, ($urandom_range(3) != 0));
      repeat ($urandom_range(4)) @(negedge clk);
    end
    drain();

    // Random loopback traffic on both DUTs
    lb_l = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      send(1'b0, DW'($urandom), a1);
      if ($urandom_range(1) == 1) begin
        @(negedge clk); drop(1'b0);
        gap = $urandom_range(10);
        repeat (gap) @(negedge clk);
      end
    end
    @(negedge clk); drop(1'b0);
    for (int i = 0; i < 6; i++) begin
      send(1'b1, DW'($urandom), a1);
      if ($urandom_range(1) == 1) begin
        @(negedge clk); drop(1'b1);
        repeat ($urandom_range(6)) @(negedge clk);
      end
    end
    @(negedge clk); drop(1'b1);
    drain();

    // Reset in the middle of a TX data phase
    send(1'b0, 8'hC3, a1);
    @(negedge clk); drop(1'b0);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    exp_l.delete(); last_l = '0;
    exp_m.delete(); last_m = '0;
    #1;
    chk("midrst_ser_out", 32'(ser_out_l), 1);
    chk("midrst_tx_ready", 32'(bus_l.tx_ready), 1);
    chk("midrst_rx_data", 32'(bus_l.rx_data), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    send(1'b0, 8'h3C, a1);
    @(negedge clk); drop(1'b0);
    drain();

    chk("queue_empty_l", 32'(exp_l.size()), 0);
    chk("queue_empty_m", 32'(exp_m.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
